// File: rtl/tetris_pkg.sv
// Shared piece-queue types: piece code, legal piece count, the empty code
// and the two-state control FSM encoding.
package tetris_pkg;
    typedef logic [2:0] piece_t;

    localparam int     NUM_PIECES = 7;
    localparam piece_t PIECE_NONE = 3'd7;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } q_state_t;
endpackage

// File: rtl/piece_fifo.sv
// Shift-register piece storage: entry 0 is the head, pop shifts toward it.
// The caller only asserts i_pop when occupied and i_push when there is room.
module piece_fifo
    import tetris_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  piece_t                 i_data,
    output piece_t [DEPTH-1:0]     o_entries,
    output logic   [3:0]           o_count
);
    piece_t [DEPTH-1:0] r_mem;
    piece_t [DEPTH-1:0] w_next;
    logic   [3:0]       r_count;
    logic   [3:0]       w_wr_idx;

    // The new piece lands at the tail as it stands after any shift.
    assign w_wr_idx = i_pop ? (r_count - 4'd1) : r_count;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        piece_t w_shift;
        if (i < DEPTH - 1) begin : g_mid
            assign w_shift = i_pop ? r_mem[i+1] : r_mem[i];
        end else begin : g_top
            assign w_shift = i_pop ? 3'd0 : r_mem[i];
        end
        assign w_next[i] = (i_push && (w_wr_idx == 4'(i))) ? i_data : w_shift;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem   <= '0;
            r_count <= 4'd0;
        end else begin
            r_mem <= w_next;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_entries = r_mem;
    assign o_count   = r_count;
endmodule

// File: rtl/piece_queue.sv
// Upcoming-piece queue: filters rand_in, applies the single-reroll rule
// against the last pushed piece, and tracks FILL/FULL plus sticky underflow.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int NUM_PIECES = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         rand_in,
    input  logic               pop,
    output logic               piece_valid,
    output logic [2:0]         piece_out,
    output logic [3*DEPTH-1:0] preview_out,
    output logic [3:0]         count,
    output logic               underflow
);
    q_state_t           r_state;
    piece_t             r_last;
    logic               r_reroll_used;
    logic               r_underflow;

    piece_t [DEPTH-1:0] w_entries;
    logic   [3:0]       w_count;
    logic               w_legal;
    logic               w_pop_eff;
    logic               w_room;
    logic               w_reroll_drop;
    logic               w_push;

    assign w_legal   = (rand_in != PIECE_NONE) && (int'(rand_in) < NUM_PIECES);
    assign w_pop_eff = pop && (w_count != 4'd0);
    assign w_room    = (r_state == FILL) || w_pop_eff;

    // Reroll bookkeeping only advances when the candidate could actually be pushed.
    assign w_reroll_drop = w_legal && w_room && (rand_in == r_last) && !r_reroll_used;
    assign w_push        = w_legal && w_room && !w_reroll_drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= FILL;
            r_last        <= PIECE_NONE;
            r_reroll_used <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (pop && (w_count == 4'd0))
                r_underflow <= 1'b1;

            if (w_push) begin
                r_last        <= rand_in;
                r_reroll_used <= 1'b0;
            end else if (w_reroll_drop) begin
                r_reroll_used <= 1'b1;
            end

            case (r_state)
                FILL: if (w_push && !w_pop_eff && (w_count == 4'(DEPTH - 1)))
                          r_state <= FULL;
                FULL: if (w_pop_eff && !w_push)
                          r_state <= FILL;
                default: r_state <= FILL;
            endcase
        end
    end

    piece_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_pop     (w_pop_eff),
        .i_data    (rand_in),
        .o_entries (w_entries),
        .o_count   (w_count)
    );

    assign count       = w_count;
    assign piece_valid = (w_count != 4'd0);
    assign piece_out   = w_entries[0];
    assign preview_out = w_entries;
    assign underflow   = r_underflow;
endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 Parameter DEPTH, default 3: number of queued pieces (head plus previews); legal range 2..8.
REQ-002 Parameter NUM_PIECES, default 7: count of legal piece codes, 0..NUM_PIECES-1.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 rand_in  input  3: candidate piece code from the random piece generator, sampled every cycle.
REQ-006 pop  input  1: game logic consumes the head piece this cycle.
REQ-007 piece_valid  output  1: head entry holds a piece.
REQ-008 piece_out  output  3: head piece code.
REQ-009 preview_out  output  3*DEPTH: all entries, entry 0 (head) in bits [2:0], entry i in bits [3i+2:3i].
REQ-010 count  output  4: number of occupied entries, 0..DEPTH.
REQ-011 underflow  output  1: sticky flag; set when pop arrives while the queue is empty.

Function
REQ-012 Queue SHALL be FIFO order: the head is the oldest pushed piece.
REQ-013 Push candidate SHALL be rand_in, sampled in the same cycle.
REQ-014 Candidate SHALL be accepted only if it lies in the range 0..NUM_PIECES-1; 3'd7 is dropped, with no push and no change to the reroll state.
REQ-015 Reroll rule: the first legal candidate equal to last_pushed SHALL be dropped and reroll_used set.
REQ-016 The next legal candidate SHALL be pushed regardless of value, and reroll_used cleared.
REQ-017 Any push of a piece different from last_pushed SHALL clear reroll_used.
REQ-018 A push SHALL occur when an accepted candidate exists and either count<DEPTH or (pop && count==DEPTH).
REQ-019 Each push SHALL update last_pushed to the pushed code.
REQ-020 Pop with count>0 SHALL remove the head; the next entry SHALL appear on piece_out the following cycle.
REQ-021 Simultaneous pop and push SHALL leave count unchanged.
REQ-022 In a simultaneous pop and push, the new piece SHALL enter at the tail after the shift.
REQ-023 Pop with count==0 SHALL be ignored for queue state and SHALL set underflow.
REQ-024 A push in the same cycle as an ignored pop SHALL still occur.
REQ-025 piece_valid SHALL equal (count!=0); piece_out, preview_out and count are registered-state outputs with no combinational path from pop.
REQ-026 Unoccupied entries SHALL read 3'd0 in preview_out.
REQ-027 Control FSM states: FILL (count<DEPTH) and FULL (count==DEPTH).
REQ-028 FILL->FULL on a push that makes count==DEPTH without a pop.
REQ-029 FULL->FILL on a pop without a push; FULL stays FULL on pop+push.
REQ-030 Fill rate SHALL be at most one piece per cycle.

Reset
REQ-031 Assertion of reset_n low SHALL immediately (asynchronously) force: count=0, piece_valid=0, piece_out=0, preview_out=0, underflow=0, last_pushed=3'd7 (none), reroll_used=0, state FILL.
REQ-032 Reset mid-operation SHALL discard all queued pieces; the first legal rand_in after deassertion is pushed with no reroll.
REQ-033 underflow SHALL clear only by reset.

Structure
REQ-034 Shared package tetris_pkg SHALL hold: piece_t (3-bit) typedef, NUM_PIECES=7, PIECE_NONE=3'd7, and the queue state enum {FILL, FULL}.
REQ-035 One sub-module, piece_fifo (shift-register storage with push/pop/count), is natural.
REQ-036 Reroll and control logic SHALL reside in piece_queue.

Verification
REQ-037 Reset release with rand_in held at 2,5,1 on successive cycles -> count 1,2,3; piece_out=2; preview_out[8:0] = {1,5,2}; no further push.
REQ-038 Empty queue, rand_in sequence 4,4,4,3 -> pushes are 4 (cycle 1), dropped (cycle 2), 4 (cycle 3), 3 (cycle 4); queue = 4,4,3.
REQ-039 rand_in=7 for 5 cycles after reset -> count stays 0, piece_valid 0.
REQ-040 rand_in=6 next cycle after 7 -> 6 pushed.
REQ-041 Full queue {0,1,2} with pop=1 and rand_in=3 -> next cycle count=3, piece_out=1, queue = 1,2,3.
REQ-042 pop=1 at count=0 with rand_in=5 -> underflow=1, count=1, piece_out=5.
REQ-043 Repeat the REQ-042 stimulus -> underflow stays 1.
REQ-044 reset_n pulsed low mid-cycle with count=2 -> outputs zero before the next clock edge.
REQ-045 After the reset pulse of REQ-044, rand_in equal to the old last_pushed -> pushed (no reroll).
